// File: rtl/io_uart_in.sv
// io_uart_in -- receive-side character peripheral on the dma_io bus.
//
// Bytes arriving from the uart_top RX path are buffered in a small FIFO.
// The CPU pops bytes by reading the data register and inspects or controls
// the block through the status/control register. A level interrupt is
// raised while the interrupt enable is set and data is pending. Read data
// joins the dma_io daisy chain: this block drives the chain only in the
// cycle after one of its own registers was read.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   uart_in_char/_we  received byte and its one-cycle strobe
//   uart_in_full      registered FIFO-full flag back to uart_top
//   dma_io_we/wadr/wdata         CPU write (word address [15:2])
//   dma_io_radr/radr_en          CPU read request (word address [15:2])
//   dma_io_rdata_in / dma_io_rdata  read-data chain in / out
//   interrupt_rx      registered level interrupt (ie & FIFO not empty)
//
// Register map
//   ADR_DATA  read: {valid, 23'd0, char}, pops one byte; 0 when empty.
//             writes are ignored.
//   ADR_STAT  read: [0] not_empty [1] full [2] overrun [3] ie
//                   [8+FDEPTH_LOG2:8] count, other bits 0; no side effects.
//             write: wdata[3] -> ie, wdata[2]=1 clears overrun.
//
// Handshake: a read issued in cycle N (radr_en with an address hit) is
// answered in cycle N+1 on dma_io_rdata; there is no back-pressure.

module io_uart_in #(
    parameter int          FDEPTH_LOG2 = 4,
    parameter logic [13:0] ADR_DATA    = 14'h3004,
    parameter logic [13:0] ADR_STAT    = 14'h3005
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_in_char,
    input  logic        uart_in_we,
    output logic        uart_in_full,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        interrupt_rx
);

    localparam int             DEPTH    = 1 << FDEPTH_LOG2;
    localparam int             CW       = FDEPTH_LOG2 + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [7:0]             r_mem [DEPTH];
    logic [FDEPTH_LOG2-1:0] r_wptr;
    logic [FDEPTH_LOG2-1:0] r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_overrun;
    logic                   r_ie;
    logic                   r_full;
    logic                   r_irq;
    logic                   r_hit_q;
    logic [31:0]            r_rdata_q;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovr_event;
    logic                   w_rd_data;
    logic                   w_rd_stat;
    logic                   w_wr_stat;
    logic [CW-1:0]          w_count_nxt;
    logic [31:0]            w_stat;
    logic [31:0]            w_data_word;
    logic                   w_unused;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);

    assign w_rd_data = dma_io_radr_en & (dma_io_radr == ADR_DATA);
    assign w_rd_stat = dma_io_radr_en & (dma_io_radr == ADR_STAT);
    assign w_wr_stat = dma_io_we & (dma_io_wadr == ADR_STAT);

    // Fullness is judged on the count at the start of the cycle, so a byte
    // arriving while full is dropped even if a pop frees a slot this cycle.
    assign w_push      = uart_in_we & ~w_full;
    assign w_ovr_event = uart_in_we & w_full;
    assign w_pop       = w_rd_data & ~w_empty;

    // Only the ie and overrun-clear bits of a write carry meaning
    assign w_unused = ^{dma_io_wdata[31:4], dma_io_wdata[1:0]};

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_comb begin
        w_stat              = '0;
        w_stat[0]           = ~w_empty;
        w_stat[1]           = w_full;
        w_stat[2]           = r_overrun;
        w_stat[3]           = r_ie;
        w_stat[8 +: CW]     = r_count;
    end

    assign w_data_word = w_empty ? 32'h0000_0000 : {1'b1, 23'd0, r_mem[r_rptr]};

    // Storage is not reset: contents are only visible through the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= uart_in_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_ie      <= 1'b0;
            r_full    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FDEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FDEPTH_LOG2'(1);
            end
            r_count <= w_count_nxt;

            if (w_wr_stat) begin
                r_ie <= dma_io_wdata[3];
            end
            // The set comes last so an overrun in the same cycle as a
            // clear request is not lost.
            if (w_wr_stat && dma_io_wdata[2]) begin
                r_overrun <= 1'b0;
            end
            if (w_ovr_event) begin
                r_overrun <= 1'b1;
            end

            r_full <= w_full;
            r_irq  <= r_ie & ~w_empty;
        end
    end

    // Read response register: one cycle after a hit it owns the chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_q   <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_hit_q <= w_rd_data | w_rd_stat;
            if (w_rd_data) begin
                r_rdata_q <= w_data_word;
            end else if (w_rd_stat) begin
                r_rdata_q <= w_stat;
            end else begin
                r_rdata_q <= '0;
            end
        end
    end

    assign dma_io_rdata = r_hit_q ? r_rdata_q : dma_io_rdata_in;
    assign uart_in_full = r_full;
    assign interrupt_rx = r_irq;

endmodule

// File: tb/tb_io_uart_in.sv
module tb_io_uart_in;

    localparam logic [13:0] ADR_DATA  = 14'h3004;
    localparam logic [13:0] ADR_STAT  = 14'h3005;
    localparam logic [13:0] ADR_OTHER = 14'h1234;
    localparam logic [31:0] CHAIN     = 32'hDEAD_BEEF;

    localparam int OP_PUSH  = 0;
    localparam int OP_READ  = 1;
    localparam int OP_WRITE = 2;
    localparam int OP_IDLE  = 3;

    typedef struct {
        int          op;
        logic [13:0] adr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_in_char;
    logic        uart_in_we;
    logic        uart_in_full;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        interrupt_rx;

    always #5 clk = ~clk;

    io_uart_in dut (
        .clk             (clk),
        .rst             (rst),
        .uart_in_char    (uart_in_char),
        .uart_in_we      (uart_in_we),
        .uart_in_full    (uart_in_full),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_radr_en  (dma_io_radr_en),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .interrupt_rx    (interrupt_rx)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set right after a falling edge; tick() lets one rising edge
    // consume them, then at the next falling edge clears the strobes and
    // scores the response to any read issued in that cycle.
    task automatic tick();
        logic        was_rd;
        logic [31:0] e;
        string       nm;
        was_rd = dma_io_radr_en;
        @(negedge clk);
        uart_in_we     = 1'b0;
        dma_io_we      = 1'b0;
        dma_io_radr_en = 1'b0;
        if (was_rd) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: read response with no expectation queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, dma_io_rdata, e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_push(input logic [7:0] b);
        uart_in_we   = 1'b1;
        uart_in_char = b;
    endtask

    task automatic set_read(input logic [13:0] adr, input logic [31:0] exp, input string nm);
        dma_io_radr_en = 1'b1;
        dma_io_radr    = adr;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic set_write(input logic [13:0] adr, input logic [31:0] data);
        dma_io_we    = 1'b1;
        dma_io_wadr  = adr;
        dma_io_wdata = data;
    endtask

    task automatic push_byte(input logic [7:0] b);
        set_push(b);
        tick();
    endtask

    task automatic rd(input logic [13:0] adr, input logic [31:0] exp, input string nm);
        set_read(adr, exp, nm);
        tick();
    endtask

    task automatic wr(input logic [13:0] adr, input logic [31:0] data);
        set_write(adr, data);
        tick();
    endtask

    task automatic add_vec(input int op, input logic [13:0] adr, input logic [31:0] data,
                           input logic [31:0] exp);
        vec_t v;
        v.op = op; v.adr = adr; v.data = data; v.exp = exp;
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        rst             = 1'b1;
        uart_in_char    = '0;
        uart_in_we      = 1'b0;
        dma_io_we       = 1'b0;
        dma_io_wadr     = '0;
        dma_io_wdata    = '0;
        dma_io_radr     = '0;
        dma_io_radr_en  = 1'b0;
        dma_io_rdata_in = CHAIN;

        // Basic push / pop / status / chain vectors
        add_vec(OP_PUSH,  '0,        32'h41, '0);
        add_vec(OP_PUSH,  '0,        32'h42, '0);
        add_vec(OP_PUSH,  '0,        32'h43, '0);
        add_vec(OP_READ,  ADR_STAT,  '0,     32'h0000_0301);
        add_vec(OP_READ,  ADR_DATA,  '0,     32'h8000_0041);
        add_vec(OP_READ,  ADR_DATA,  '0,     32'h8000_0042);
        add_vec(OP_READ,  ADR_DATA,  '0,     32'h8000_0043);
        add_vec(OP_READ,  ADR_DATA,  '0,     32'h0000_0000);
        add_vec(OP_IDLE,  '0,        '0,     CHAIN);
        add_vec(OP_READ,  ADR_OTHER, '0,     CHAIN);
        add_vec(OP_WRITE, ADR_DATA,  32'hFF, '0);
        add_vec(OP_READ,  ADR_STAT,  '0,     32'h0000_0000);

        idle(2);
        rst = 1'b0;
        check("reset_full", {31'd0, uart_in_full}, 32'd0);
        check("reset_irq", {31'd0, interrupt_rx}, 32'd0);
        check("reset_chain", dma_io_rdata, CHAIN);
        rd(ADR_STAT, 32'h0, "reset_stat");

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_PUSH:  push_byte(vecs[i].data[7:0]);
                OP_READ:  rd(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d_read", i));
                OP_WRITE: wr(vecs[i].adr, vecs[i].data);
                default: begin
                    tick();
                    check($sformatf("vec%0d_idle", i), dma_io_rdata, vecs[i].exp);
                end
            endcase
        end

        // Fill to 16, then one byte too many
        for (int i = 0; i < 15; i++) push_byte(8'(8'h10 + i));
        check("full_at_15", {31'd0, uart_in_full}, 32'd0);
        push_byte(8'h1F);
        tick();
        check("full_at_16", {31'd0, uart_in_full}, 32'd1);
        push_byte(8'h20);
        rd(ADR_STAT, 32'h0000_1007, "stat_overflow");

        // Full FIFO: push and pop together -> push dropped, overrun set
        wr(ADR_STAT, 32'h4);
        rd(ADR_STAT, 32'h0000_1003, "stat_ovr_cleared");
        set_push(8'hEE);
        set_read(ADR_DATA, 32'h8000_0010, "full_pushpop_data");
        tick();
        rd(ADR_STAT, 32'h0000_0F05, "stat_full_pushpop");
        for (int i = 1; i < 16; i++) rd(ADR_DATA, 32'h8000_0000 | 32'(8'h10 + i), "drain_full");
        rd(ADR_DATA, 32'h0, "drain_full_empty");
        idle(1);
        check("not_full_after_drain", {31'd0, uart_in_full}, 32'd0);

        // Partial FIFO: simultaneous push/pop across pointer wrap
        wr(ADR_STAT, 32'h4);
        for (int i = 0; i < 12; i++) push_byte(8'(8'hA0 + i));
        for (int i = 0; i < 10; i++) rd(ADR_DATA, 32'h8000_0000 | 32'(8'hA0 + i), "partial_pop");
        for (int i = 0; i < 8; i++) begin
            logic [7:0] eb;
            eb = (i < 2) ? 8'(8'hAA + i) : 8'(8'hB0 + i - 2);
            set_push(8'(8'hB0 + i));
            set_read(ADR_DATA, {1'b1, 23'd0, eb}, "wrap_pushpop");
            tick();
        end
        rd(ADR_STAT, 32'h0000_0201, "stat_wrap");
        rd(ADR_DATA, 32'h8000_00B6, "wrap_tail0");
        rd(ADR_DATA, 32'h8000_00B7, "wrap_tail1");
        rd(ADR_DATA, 32'h0, "wrap_empty");

        // Interrupt follows ie & not_empty with one cycle of delay
        push_byte(8'h55);
        idle(2);
        check("irq_disabled", {31'd0, interrupt_rx}, 32'd0);
        wr(ADR_STAT, 32'h8);
        tick();
        check("irq_set", {31'd0, interrupt_rx}, 32'd1);
        rd(ADR_STAT, 32'h0000_0109, "stat_ie");
        rd(ADR_DATA, 32'h8000_0055, "irq_pop");
        tick();
        check("irq_clear", {31'd0, interrupt_rx}, 32'd0);

        // Overrun clear colliding with an overrun event: overrun stays set
        for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
        set_push(8'h77);
        set_write(ADR_STAT, 32'hC);
        tick();
        rd(ADR_STAT, 32'h0000_100F, "stat_clear_vs_event");
        wr(ADR_STAT, 32'h4);
        rd(ADR_STAT, 32'h0000_1003, "stat_clear_alone");

        // Reset mid-stream discards buffered bytes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
        wr(ADR_STAT, 32'h8);
        idle(2);
        check("irq_before_rst", {31'd0, interrupt_rx}, 32'd1);
        rd(ADR_STAT, 32'h0000_0509, "stat_5_bytes");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_full", {31'd0, uart_in_full}, 32'd0);
        check("rst_irq", {31'd0, interrupt_rx}, 32'd0);
        rd(ADR_STAT, 32'h0, "rst_stat");
        rd(ADR_DATA, 32'h0, "rst_data");
        tick();
        check("rst_irq_later", {31'd0, interrupt_rx}, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
